// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Desc     : Shared defaults, duty type and threshold helper for the PWM core.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int C_PERIOD   = 100;
    localparam int C_STEP     = 10;
    localparam int C_MAX_MULT = 10;
    localparam int C_PRESCALE = 1;

    typedef logic [3:0] duty_mult_t;

    // Clamping happens before the multiply so an input of 15 cannot overflow.
    function automatic logic [15:0] clamp_duty(
        input duty_mult_t mult,
        input int         step     = C_STEP,
        input int         max_mult = C_MAX_MULT
    );
        int m;
        m = (int'(mult) > max_mult) ? max_mult : int'(mult);
        return 16'(m * step);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : pwm_prescaler
// Desc     : Clock-enable divider; tick is high once every PRESCALE cycles.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESCALE = C_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == C_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_counter.sv
`default_nettype none
// ============================================================================
// Module   : pwm_counter
// Desc     : Fixed-frequency PWM with 10% duty steps and period-aligned shadow
//            threshold. Define PWM_COUNTER_STATUS_EN for period_start and
//            duty_clamped status outputs.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int PERIOD   = C_PERIOD,
    parameter int STEP     = C_STEP,
    parameter int MAX_MULT = C_MAX_MULT,
    parameter int PRESCALE = C_PRESCALE
) (
    input  logic       clk,
    input  logic       rst,
    input  duty_mult_t duty_multiplier,
    output logic       pwm_out
`ifdef PWM_COUNTER_STATUS_EN
    ,
    output logic       period_start,
    output logic       duty_clamped
`endif
);

    localparam int               CNT_W  = $clog2(PERIOD);
    localparam int               THR_W  = $clog2(PERIOD + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PERIOD - 1);

    logic             started_q;
    logic             w_tick_raw;
    logic             w_tick;
    logic             w_load;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [THR_W-1:0] shadow_q;
    logic [THR_W-1:0] shadow_d;
    logic             pwm_q;
    logic             pwm_d;

    // The first edge after reset only latches the duty, so period 0 is full length.
    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (started_q),
        .tick (w_tick_raw)
    );

    assign w_tick = w_tick_raw & started_q;
    assign w_load = ~started_q | (w_tick & (count_q == C_LAST));

    always_comb begin
        count_d  = count_q;
        shadow_d = shadow_q;
        if (w_tick) begin
            count_d = (count_q == C_LAST) ? '0 : count_q + CNT_W'(1);
        end
        if (w_load) begin
            shadow_d = THR_W'(clamp_duty(duty_multiplier, STEP, MAX_MULT));
        end
        // Comparing next-state values keeps the output aligned with the count.
        pwm_d = (THR_W'(count_d) < shadow_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started_q <= 1'b0;
            count_q   <= '0;
            shadow_q  <= '0;
            pwm_q     <= 1'b0;
        end else begin
            started_q <= 1'b1;
            count_q   <= count_d;
            shadow_q  <= shadow_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

`ifdef PWM_COUNTER_STATUS_EN
    logic period_start_q;
    logic duty_clamped_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_start_q <= 1'b0;
            duty_clamped_q <= 1'b0;
        end else begin
            period_start_q <= w_load;
            if (w_load) begin
                duty_clamped_q <= (int'(duty_multiplier) > MAX_MULT);
            end
        end
    end

    assign period_start = period_start_q;
    assign duty_clamped = duty_clamped_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_counter
// Desc     : Scoreboard bench for pwm_counter (PRESCALE=1 and PRESCALE=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_counter;
    import pwm_pkg::*;

    localparam int LEN_A = 100;
    localparam int P_B   = 4;
    localparam int LEN_B = 100 * P_B;

    typedef struct {
        int hi;
        int clamped;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    duty_mult_t duty_a;
    duty_mult_t duty_b;
    logic       pwm_a;
    logic       pwm_b;
    logic       started;
`ifdef PWM_COUNTER_STATUS_EN
    logic       ps_a, dc_a, ps_b, dc_b;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    exp_t e_a;

    always #5 clk = ~clk;

    pwm_counter #(.PRESCALE(1)) u_dut_a (
        .clk             (clk),
        .rst             (rst),
        .duty_multiplier (duty_a),
        .pwm_out         (pwm_a)
`ifdef PWM_COUNTER_STATUS_EN
        ,
        .period_start    (ps_a),
        .duty_clamped    (dc_a)
`endif
    );

    pwm_counter #(.PRESCALE(P_B)) u_dut_b (
        .clk             (clk),
        .rst             (rst),
        .duty_multiplier (duty_b),
        .pwm_out         (pwm_b)
`ifdef PWM_COUNTER_STATUS_EN
        ,
        .period_start    (ps_b),
        .duty_clamped    (dc_b)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // High cycles per period: clamp to 10 steps of 10% of a 100-tick period.
    function automatic int model_high(input int v, input int p);
        int m;
        m = (v > 10) ? 10 : v;
        return m * 10 * p;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) started <= 1'b0;
        else      started <= 1'b1;
    end

    // Monitor A: one window per period, compared against the scoreboard.
    int ph_a = 0, hi_a = 0, psn_a = 0;
    bit low_a = 1'b0, bad_a = 1'b0, ps0_a = 1'b0;
    always @(negedge clk) begin
        if (!rst || !started) begin
            ph_a = 0; hi_a = 0; psn_a = 0; low_a = 1'b0; bad_a = 1'b0; ps0_a = 1'b0;
        end else begin
            if (pwm_a) begin
                hi_a++;
                if (low_a) bad_a = 1'b1;
            end else begin
                low_a = 1'b1;
            end
`ifdef PWM_COUNTER_STATUS_EN
            if (ps_a) psn_a++;
            if (ph_a == 0) ps0_a = ps_a;
`endif
            ph_a++;
            if (ph_a == LEN_A) begin
                if (expq.size() == 0) begin
                    chk("a_scoreboard_underflow", expq.size(), 1);
                end else begin
                    e_a = expq.pop_front();
                    chk("a_high_cycles", hi_a, e_a.hi);
                    chk("a_high_contiguous", int'(bad_a), 0);
`ifdef PWM_COUNTER_STATUS_EN
                    chk("a_duty_clamped", int'(dc_a), e_a.clamped);
                    chk("a_period_start_count", psn_a, 1);
                    chk("a_period_start_first", int'(ps0_a), 1);
`endif
                end
                ph_a = 0; hi_a = 0; psn_a = 0; low_a = 1'b0; bad_a = 1'b0; ps0_a = 1'b0;
            end
        end
    end

    // Monitor B: prescaled instance with a fixed duty request.
    int ph_b = 0, hi_b = 0, psn_b = 0;
    bit low_b = 1'b0, bad_b = 1'b0;
    always @(negedge clk) begin
        if (!rst || !started) begin
            ph_b = 0; hi_b = 0; psn_b = 0; low_b = 1'b0; bad_b = 1'b0;
        end else begin
            if (pwm_b) begin
                hi_b++;
                if (low_b) bad_b = 1'b1;
            end else begin
                low_b = 1'b1;
            end
`ifdef PWM_COUNTER_STATUS_EN
            if (ps_b) psn_b++;
`endif
            ph_b++;
            if (ph_b == LEN_B) begin
                chk("b_high_cycles", hi_b, model_high(int'(duty_b), P_B));
                chk("b_high_contiguous", int'(bad_b), 0);
`ifdef PWM_COUNTER_STATUS_EN
                chk("b_period_start_count", psn_b, 1);
                chk("b_duty_clamped", int'(dc_b), 0);
`endif
                ph_b = 0; hi_b = 0; psn_b = 0; low_b = 1'b0; bad_b = 1'b0;
            end
        end
    end

    // Called at the negedge just before a period-start edge; returns one period later.
    task automatic run_period(input int v, input int mid, input int w);
        duty_a = duty_mult_t'(v);
        expq.push_back('{hi: model_high(v, 1), clamped: int'(v > 10)});
        for (int i = 1; i <= LEN_A; i++) begin
            @(negedge clk);
            if (i == mid) duty_a = duty_mult_t'(w);
        end
    endtask

    initial begin
        duty_a = 4'd5;
        duty_b = 4'd2;
        rst    = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("reset_pwm_a", int'(pwm_a), 0);
            chk("reset_pwm_b", int'(pwm_b), 0);
        end
        rst = 1'b1;
        run_period(5, 0, 0);

        for (int v = 0; v <= 10; v++) begin
            run_period(v, 0, 0);
            run_period(v, 0, 0);
        end

        run_period(13, 40, 2);
        run_period(15, 0, 0);

        run_period(3, 51, 7);
        run_period(7, 0, 0);

        duty_a = 4'd8;
        repeat (6) @(negedge clk);
        #1;
        chk("pre_reset_pwm_a", int'(pwm_a), 1);
        rst = 1'b0;
        #1;
        chk("async_reset_pwm_a", int'(pwm_a), 0);
        chk("async_reset_pwm_b", int'(pwm_b), 0);
        repeat (3) begin
            @(negedge clk);
            chk("held_reset_pwm_a", int'(pwm_a), 0);
        end
        rst = 1'b1;
        run_period(8, 0, 0);

        repeat (8) begin
            run_period(int'($urandom_range(0, 15)), int'($urandom_range(1, 100)),
                       int'($urandom_range(0, 15)));
        end

        @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/pwm_counter.md
Name: pwm_counter

Overview:
- Fixed-frequency PWM generator.
- The duty cycle is selected in 10% steps by a 4-bit multiplier: 0 gives 0%, 10 gives 100%, and values 11..15 saturate to 100%.
- A free-running period counter is compared against a duty threshold, which is shadow-latched at each period boundary so that duty changes never glitch the output.
- It sits between a control/register block, which supplies `duty_multiplier`, and an output pin or driver stage.

Parameters:
- PERIOD, default 100: clock ticks per PWM period after the prescaler; must equal STEP*MAX_MULT.
- STEP, default 10: counter ticks added to the high time per unit of `duty_multiplier`.
- MAX_MULT, default 10: multiplier value giving 100% duty; larger inputs clamp to it.
- PRESCALE, default 1: clock enable divider; the counter advances once every PRESCALE clk cycles (1 means every cycle).

Ports:
- clk, input, 1: system clock, rising-edge active.
- rst, input, 1: asynchronous, active-low reset (0 means reset asserted).
- duty_multiplier, input, 4: duty request in units of STEP/PERIOD (10%); sampled only at period start.
- pwm_out, output, 1: registered PWM output.

Behaviour:
- Reset (rst=0), asynchronous: prescaler count = 0, period count = 0, duty shadow = 0, pwm_out = 0. All are held while rst=0.
- Reset release: the first rising clk edge with rst=1 starts normal operation at count 0.
- Prescaler:
  - tick = 1 when the prescaler count equals PRESCALE-1.
  - The prescaler count wraps to 0 on tick.
  - With PRESCALE=1, tick is constantly 1.
- Period counter, width $clog2(PERIOD):
  - On tick, count increments.
  - At PERIOD-1 it wraps to 0.
- Duty shadow:
  - On tick while count==PERIOD-1, and also on the first edge after reset release, the shadow loads min(duty_multiplier, MAX_MULT)*STEP.
  - Otherwise it holds.
  - Mid-period changes of duty_multiplier take effect at the next period start.
- Output:
  - On each clk edge, pwm_out <= (next_count < shadow_next).
  - Registering the next-state values gives pwm_out exactly high for shadow*PRESCALE cycles per period with zero lag relative to count.
  - shadow=0 gives constant 0.
  - shadow=PERIOD gives constant 1 with no one-cycle low glitch at wrap.
- Arithmetic: the multiply uses a width wide enough for MAX_MULT*STEP, with no overflow for input 15 thanks to the clamp before the multiply.
- Reset mid-period: pwm_out drops to 0 immediately (asynchronously); the counter restarts from 0 after release.

Optional Feature:
- Macro PWM_COUNTER_STATUS_EN.
- When defined, two extra outputs are added:
  - period_start (1-bit pulse, high for one clk cycle when the shadow reloads).
  - duty_clamped (registered; 1 when the latched duty_multiplier > MAX_MULT).
  - Both reset to 0.
- When undefined, neither port nor logic exists; core behaviour is identical in both builds.

Decomposition:
- Package pwm_pkg holds:
  - the default constants PERIOD, STEP, MAX_MULT, PRESCALE;
  - typedef duty_mult_t, a 4-bit logic type;
  - a function clamp_duty(duty_mult_t) returning the threshold.
- One natural sub-module, pwm_prescaler: parameterised clock-enable generator with clk, rst and tick output.
- The compare and shadow logic stay in pwm_counter.

Test Plan:
- Reset: hold rst=0 for 4 cycles with duty_multiplier=5 -> pwm_out=0 throughout; after release pwm_out starts high in the first period.
- Sweep: duty_multiplier 0,1,2,...,10, each held for 2 full periods (200 cycles, PRESCALE=1) -> pwm_out high count per period = 0,10,20,...,100 cycles.
- Saturation: duty_multiplier=13 and 15 -> pwm_out constantly 1; with PWM_COUNTER_STATUS_EN defined, duty_clamped=1.
- Mid-period change: switch from 3 to 7 at count 50 -> the current period keeps 30 high cycles; the next period has 70.
- Async reset mid-operation: drive rst low at count 5 while duty=8 -> pwm_out falls in the same timestep without a clock edge; after release, high for 80 cycles.
- Prescaler: PRESCALE=4, duty_multiplier=2 -> period 400 clk cycles, high for 80; period_start pulses every 400 cycles.
